scan_select_gen: RTL and testbench

- Registered channel sequencer that drives the 3-bit select input of the 3-to-8 one-hot decoder.
- Steps through the enabled channels in ascending order and holds each one for a programmable dwell time.
- Runs in continuous or single-sweep mode and flags the end of each sweep.
- Used for LED/display multiplexing, keypad row scanning and round-robin channel strobing.

---
 rtl/scan_select_gen.sv | 111 +++++++++++
 tb/tb_scan_select_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/scan_select_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scan_select_gen: registered channel sequencer for a 3-to-8 decoder select |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module scan_select_gen #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               start,
  input  logic [7:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         s,
  output logic               s_valid,
  output logic               busy,
  output logic               sweep_done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

  state_t             state, state_nxt;
  logic [2:0]         s_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic               done_nxt;
  logic [3:0]         adv;

  function automatic logic [2:0] first_ch(input logic [7:0] m);
    first_ch = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) first_ch = 3'(i);
  endfunction

  // Returns {wrap, index}: lowest enabled channel above c, else wrap to first.
  function automatic logic [3:0] next_ch(input logic [2:0] c, input logic [7:0] m);
    next_ch = {1'b1, first_ch(m)};
    for (int i = 7; i >= 0; i--)
      if (m[i] && (i > int'(c))) next_ch = {1'b0, 3'(i)};
  endfunction

  assign adv = next_ch(s, ch_mask);

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (en && (ch_mask != 8'd0) && (!mode || start)) begin
          state_nxt = SCAN;
          s_nxt     = first_ch(ch_mask);
          cnt_nxt   = dwell;
        end
      end
      SCAN: begin
        if (!en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else if (ch_mask == 8'd0) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (!adv[3]) begin
          s_nxt   = adv[2:0];
          cnt_nxt = dwell;
        end else if (!mode) begin
          s_nxt    = adv[2:0];
          cnt_nxt  = dwell;
          done_nxt = 1'b1;
        end else begin
          // Single sweep complete: park on the last channel.
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s          <= 3'd0;
      cnt        <= '0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      s          <= s_nxt;
      cnt        <= cnt_nxt;
      sweep_done <= done_nxt;
    end
  end

  assign busy    = (state == SCAN);
  assign s_valid = busy;

endmodule
`default_nettype wire

// File: tb/tb_scan_select_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_scan_select_gen: directed + random bench with a channel-list model     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_scan_select_gen;

  localparam int DWELL_W = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               mode;
  logic               start;
  logic [7:0]         ch_mask;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         s;
  logic               s_valid;
  logic               busy;
  logic               sweep_done;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_busy;
  int m_s;
  int m_left;
  bit m_done;

  scan_select_gen #(.DWELL_W(DWELL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .start      (start),
    .ch_mask    (ch_mask),
    .dwell      (dwell),
    .s          (s),
    .s_valid    (s_valid),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_s = 0; m_left = 0; m_done = 0;
  endtask

  // One clock edge of the scanning rules, using the inputs present at the edge.
  task automatic model_edge();
    int chans[$];
    int pick;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_done = 0;
    for (int i = 0; i < 8; i++) if (ch_mask[i]) chans.push_back(i);
    if (!m_busy) begin
      if (en && chans.size() > 0 && (!mode || start)) begin
        m_busy = 1; m_s = chans[0]; m_left = int'(dwell);
      end
    end else if (!en) begin
      m_busy = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
    end else if (chans.size() == 0) begin
      m_busy = 0;
    end else begin
      pick = -1;
      foreach (chans[k]) if (pick < 0 && chans[k] > m_s) pick = chans[k];
      if (pick >= 0) begin
        m_s = pick; m_left = int'(dwell);
      end else begin
        m_done = 1;
        if (!mode) begin
          m_s = chans[0]; m_left = int'(dwell);
        end else begin
          m_busy = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".s"},          int'(s),          m_s);
    chk({tag, ".s_valid"},    int'(s_valid),    int'(m_busy));
    chk({tag, ".busy"},       int'(busy),       int'(m_busy));
    chk({tag, ".sweep_done"}, int'(sweep_done), int'(m_done));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; start = 1'b0;
    ch_mask = 8'h00; dwell = '0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    run("idle", 3);

    // Continuous, all channels, dwell 0
    en = 1'b1; ch_mask = 8'hFF;
    cycle("ff_entry");
    chk("ff_first_s", int'(s), 0);
    run("ff_d0", 20);

    // Sparse mask with dwell 2
    en = 1'b0; cycle("gap1");
    en = 1'b1; ch_mask = 8'hA4; dwell = 16'd2;
    run("a4_d2", 30);

    // Single sweep, second start while busy
    en = 1'b0; cycle("gap2");
    en = 1'b1; mode = 1'b1; ch_mask = 8'h81; dwell = 16'd1;
    run("m1_nostart", 2);
    start = 1'b1; cycle("m1_start");
    start = 1'b0; cycle("m1_run");
    start = 1'b1; cycle("m1_busy_start");
    start = 1'b0; run("m1_run", 6);
    chk("m1_parked_s", int'(s), 7);

    // Drop enable at channel 3, then restart
    mode = 1'b0; ch_mask = 8'hFF; dwell = 16'd1;
    for (int i = 0; i < 40 && !(m_busy && m_s == 3); i++) cycle("to3");
    chk("reached3", m_s, 3);
    en = 1'b0; cycle("en_drop");
    chk("en_drop_s", int'(s), 3);
    run("en_low", 2);
    en = 1'b1; cycle("re_en");
    chk("re_en_s", int'(s), 0);
    run("re_en_run", 4);

    // Mask cleared mid-scan, then single channel
    ch_mask = 8'h00; run("mask0", 5);
    ch_mask = 8'h10; dwell = 16'd3; run("single4", 14);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    #3 rst_n = 1'b1; en = 1'b0;
    run("post_rst_idle", 3);
    en = 1'b1; ch_mask = 8'h66; dwell = 16'd0;
    run("post_rst_run", 10);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      en    = ($urandom_range(0, 19) != 0);
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      if ($urandom_range(0, 11) == 0)
        ch_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 15) == 0) dwell = DWELL_W'($urandom_range(0, 3));
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
